// File: rtl/matrix_mult_seq_if.sv
// matrix_mult_seq_if: start/busy/done handshake and flattened operand/result
// buses for the sequential matrix multiplier.
//   start, signed_mode, accumulate : request and its mode bits (master -> slave)
//   A, B  : N*N*DW operand matrices, element (i,j) at [(i*N+j)*DW +: DW]
//   C     : N*N*CW result matrix, element (i,j) at [(i*N+j)*CW +: CW]
//   busy, done, ovf : status (slave -> master)
interface matrix_mult_seq_if #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int CW = 32
);
  logic              start;
  logic              signed_mode;
  logic              accumulate;
  logic [N*N*DW-1:0] A;
  logic [N*N*DW-1:0] B;
  logic [N*N*CW-1:0] C;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (output start, signed_mode, accumulate, A, B,
                  input  C, busy, done, ovf);
  modport slave  (input  start, signed_mode, accumulate, A, B,
                  output C, busy, done, ovf);
endinterface

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: C = A*B or C = C + A*B for NxN matrices through one shared
// multiply-accumulate datapath, signed or unsigned, with saturating results.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears C, status and counters)
//   bus   : matrix_mult_seq_if slave (start/mode in, A/B in, C/busy/done/ovf out)
// One element costs N MAC cycles plus one WB cycle; the done pulse lands one
// cycle after the final WB (FIN), so it follows the start edge by N*N*(N+1)+1.
module matrix_mult_seq #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int CW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  matrix_mult_seq_if.slave bus
);
  localparam int PW = (CW > 2*DW) ? CW : 2*DW;
  // Headroom for N products plus a preloaded C value in either mode.
  localparam int AW = PW + $clog2(N) + 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [AW-1:0] SMAX = {{(AW-CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  localparam logic signed [AW-1:0] UMAX = {{(AW-CW){1'b0}}, {CW{1'b1}}};

  typedef enum logic [2:0] {IDLE, MAC, WB, FIN, DONE} state_t;

  typedef struct packed {
    logic [N*N*DW-1:0] a;
    logic [N*N*DW-1:0] b;
    logic              smode;
    logic              accum;
  } req_t;

  state_t            state;
  req_t              req;
  logic [IW-1:0]     i_q, j_q, k_q;
  logic signed [AW-1:0] acc;
  logic [N*N*CW-1:0] c_q;
  logic              done_q, ovf_q;

  function automatic logic signed [AW-1:0] ext_op(input logic [DW-1:0] v, input logic s);
    ext_op = s ? {{(AW-DW){v[DW-1]}}, v} : {{(AW-DW){1'b0}}, v};
  endfunction

  function automatic logic signed [AW-1:0] ext_c(input logic [CW-1:0] v, input logic s);
    ext_c = s ? {{(AW-CW){v[CW-1]}}, v} : {{(AW-CW){1'b0}}, v};
  endfunction

  int                   ia, ib, ic, nc;
  logic signed [AW-1:0] prod;
  logic                 last_j, last_el;
  logic [IW-1:0]        ni, nj;
  logic [CW-1:0]        sat_val;
  logic                 sat_hit;
  logic signed [AW-1:0] pre_nxt;

  always_comb begin
    ia      = int'(i_q) * N + int'(k_q);
    ib      = int'(k_q) * N + int'(j_q);
    ic      = int'(i_q) * N + int'(j_q);
    prod    = ext_op(req.a[ia*DW +: DW], req.smode) * ext_op(req.b[ib*DW +: DW], req.smode);
    last_j  = (j_q == IW'(N-1));
    last_el = last_j && (i_q == IW'(N-1));
    nj      = last_j ? '0 : j_q + IW'(1);
    ni      = last_j ? i_q + IW'(1) : i_q;
    // Keep the preload index in range on the final element; its value is unused.
    nc      = last_el ? 0 : int'(ni) * N + int'(nj);
    pre_nxt = req.accum ? ext_c(c_q[nc*CW +: CW], req.smode) : '0;
    sat_val = acc[CW-1:0];
    sat_hit = 1'b0;
    if (req.smode) begin
      if (acc > SMAX) begin
        sat_val = {1'b0, {(CW-1){1'b1}}};
        sat_hit = 1'b1;
      end else if (acc < SMIN) begin
        sat_val = {1'b1, {(CW-1){1'b0}}};
        sat_hit = 1'b1;
      end
    end else begin
      if (acc > UMAX) begin
        sat_val = '1;
        sat_hit = 1'b1;
      end else if (acc < 0) begin
        sat_val = '0;
        sat_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc    <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            req.a     <= bus.A;
            req.b     <= bus.B;
            req.smode <= bus.signed_mode;
            req.accum <= bus.accumulate;
            ovf_q     <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc       <= bus.accumulate ? ext_c(c_q[CW-1:0], bus.signed_mode) : '0;
            state     <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod;
          if (k_q == IW'(N-1)) state <= WB;
          else                 k_q   <= k_q + IW'(1);
        end
        WB: begin
          c_q[ic*CW +: CW] <= sat_val;
          if (sat_hit) ovf_q <= 1'b1;
          k_q <= '0;
          acc <= pre_nxt;
          if (last_el) begin
            i_q   <= '0;
            j_q   <= '0;
            state <= FIN;
          end else begin
            i_q   <= ni;
            j_q   <= nj;
            state <= MAC;
          end
        end
        FIN: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.C    = c_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
endmodule
